// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the execute push-button and
// the 16 slide switches. The button becomes a one-cycle exec strobe plus a
// debounced level. The switches become a stable word with a change strobe.
module input_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic [15:0] sw_raw,
  output logic        exec,
  output logic        exec_level,
  output logic [15:0] inp,
  output logic        inp_chg
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

  // A count of LAST before the current sample means this sample is the
  // DEBOUNCE_CYCLES-th in a row.
  localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

  logic        r_btn_s1, r_btn_s2;
  logic [15:0] r_sw_s1, r_sw_s2;
  btn_state_t  r_state;
  logic [15:0] r_cnt;
  logic        r_exec, r_lvl;
  logic [15:0] r_cand, r_scnt, r_inp;
  logic        r_chg;

  logic        w_btn;
  logic [15:0] w_cnt_inc;

  // Normalise polarity after the second flop so that 1 always means pressed.
  assign w_btn     = r_btn_s2 ^ BTN_ACTIVE_LOW;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Two-flop synchronisers. Reset loads the pins' inactive level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_btn_s1 <= BTN_ACTIVE_LOW;
      r_btn_s2 <= BTN_ACTIVE_LOW;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Button debounce FSM. exec fires once, on the edge a press is accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_exec  <= 1'b0;
      r_lvl   <= 1'b0;
    end else begin
      r_exec <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_btn) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= 16'd1;
          end
        end
        PRESS_WAIT: begin
          if (!w_btn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt >= LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_exec  <= 1'b1;
            r_lvl   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          r_lvl <= 1'b1;
          if (!w_btn) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= 16'd1;
          end
        end
        RELEASE_WAIT: begin
          if (w_btn) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt >= LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
        end
      endcase
    end
  end

  // Switch debounce. Any change restarts the whole word. The word is
  // published only after a full stable window, and only if it is new.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cand <= '0;
      r_scnt <= '0;
      r_inp  <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      if (r_sw_s2 != r_cand) begin
        r_cand <= r_sw_s2;
        r_scnt <= 16'd1;
      end else begin
        if (r_scnt < DEBOUNCE_CYCLES) r_scnt <= r_scnt + 16'd1;
        if (r_scnt >= LAST && r_cand != r_inp) begin
          r_inp <= r_cand;
          r_chg <= 1'b1;
        end
      end
    end
  end

  assign exec       = r_exec;
  assign exec_level = r_lvl;
  assign inp        = r_inp;
  assign inp_chg    = r_chg;

endmodule
